// File: rtl/vx_perf_cache_reader_pkg.sv
// Shared definitions for the cache perf-counter readout path: counter indices,
// readout FSM states and request-count normalisation.
package vx_perf_cache_reader_pkg;

  localparam int PERF_CTR_BITS = 44;
  localparam int NUM_PERF_CTRS = 8;

  localparam int PERF_IDX_READS        = 0;
  localparam int PERF_IDX_WRITES       = 1;
  localparam int PERF_IDX_READ_MISSES  = 2;
  localparam int PERF_IDX_WRITE_MISSES = 3;
  localparam int PERF_IDX_BANK_STALLS  = 4;
  localparam int PERF_IDX_MSHR_STALLS  = 5;
  localparam int PERF_IDX_MEM_STALLS   = 6;
  localparam int PERF_IDX_CRSP_STALLS  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SNAP = 2'd1,
    ST_SEND = 2'd2
  } perf_rd_state_e;

  // Beats per readout: 0 means 1, anything past 8 is clamped so no index repeats.
  function automatic logic [3:0] perf_beats(input logic [3:0] count);
    if (count == 4'd0) return 4'd1;
    if (count > 4'd8)  return 4'd8;
    return count;
  endfunction

endpackage

// File: rtl/vx_perf_cache_reader_if.sv
// Live free-running cache perf counters, driven by the cache (master) and
// sampled by readers (slave).
interface vx_perf_cache_reader_if #(
  parameter int CTR_W    = vx_perf_cache_reader_pkg::PERF_CTR_BITS,
  parameter int NUM_CTRS = vx_perf_cache_reader_pkg::NUM_PERF_CTRS
);
  logic [NUM_CTRS-1:0][CTR_W-1:0] ctr;

  modport master (output ctr);
  modport slave  (input  ctr);
endinterface

// File: rtl/vx_perf_cache_reader_snap_bank.sv
// Snapshot/baseline register pair for all counters; capture and rebase act on
// one edge, the indexed delta read is combinational (zero latency, no backpressure).
module vx_perf_cache_reader_snap_bank #(
  parameter int CTR_W    = vx_perf_cache_reader_pkg::PERF_CTR_BITS,
  parameter int NUM_CTRS = vx_perf_cache_reader_pkg::NUM_PERF_CTRS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           capture,
  input  logic                           rebase,
  input  logic [NUM_CTRS-1:0][CTR_W-1:0] live,
  input  logic [2:0]                     rd_idx,
  output logic [CTR_W-1:0]               rd_delta
);

  logic [NUM_CTRS-1:0][CTR_W-1:0] snap_q;
  logic [NUM_CTRS-1:0][CTR_W-1:0] base_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      snap_q <= '0;
      base_q <= '0;
    end else begin
      if (capture) snap_q <= live;
      if (rebase)  base_q <= snap_q;
    end
  end

  // Modular subtraction gives the right delta across counter wrap-around.
  assign rd_delta = snap_q[rd_idx] - base_q[rd_idx];

endmodule

// File: rtl/vx_perf_cache_reader.sv
// Reads a window of cache perf counters as baseline-relative deltas; first beat 2
// cycles after request accept; response outputs hold while rsp_ready is low.
module vx_perf_cache_reader
  import vx_perf_cache_reader_pkg::*;
#(
  parameter int CTR_W    = PERF_CTR_BITS,
  parameter int NUM_CTRS = NUM_PERF_CTRS
) (
  input  logic                   clk,
  input  logic                   reset,
  vx_perf_cache_reader_if.slave  perf_cache_if,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_start,
  input  logic [3:0]             req_count,
  input  logic                   req_clear,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [CTR_W-1:0]       rsp_data,
  output logic [2:0]             rsp_idx,
  output logic                   rsp_last
);

  perf_rd_state_e state_q;
  logic [3:0]     beat_q;
  logic [3:0]     count_q;
  logic           clear_q;
  logic           capture;
  logic           rebase;

  assign req_ready = (state_q == ST_IDLE);
  assign capture   = (state_q == ST_SNAP);
  assign rebase    = (state_q == ST_SEND) && rsp_valid && rsp_ready && rsp_last && clear_q;

  vx_perf_cache_reader_snap_bank #(
    .CTR_W    (CTR_W),
    .NUM_CTRS (NUM_CTRS)
  ) u_snap_bank (
    .clk      (clk),
    .reset    (reset),
    .capture  (capture),
    .rebase   (rebase),
    .live     (perf_cache_if.ctr),
    .rd_idx   (rsp_idx),
    .rd_delta (rsp_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      count_q   <= '0;
      clear_q   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_idx   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            count_q <= perf_beats(req_count);
            clear_q <= req_clear;
            rsp_idx <= req_start;
            state_q <= ST_SNAP;
          end
        end
        ST_SNAP: begin
          state_q   <= ST_SEND;
          rsp_valid <= 1'b1;
          beat_q    <= '0;
          rsp_last  <= (count_q == 4'd1);
        end
        ST_SEND: begin
          if (rsp_ready) begin
            if (rsp_last) begin
              state_q   <= ST_IDLE;
              rsp_valid <= 1'b0;
              rsp_last  <= 1'b0;
            end else begin
              // 3-bit index wraps 7->0 on its own.
              beat_q   <= beat_q + 4'd1;
              rsp_idx  <= rsp_idx + 3'd1;
              rsp_last <= ((beat_q + 4'd2) == count_q);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_perf_cache_reader.sv
// Bench for vx_perf_cache_reader: directed scenarios plus randomized readouts
// checked against a snapshot/baseline model.
module tb_vx_perf_cache_reader;
  import vx_perf_cache_reader_pkg::*;

  localparam int CTR_W = 44;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_start;
  logic [3:0]       req_count;
  logic             req_clear;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [CTR_W-1:0] rsp_data;
  logic [2:0]       rsp_idx;
  logic             rsp_last;

  vx_perf_cache_reader_if #(.CTR_W(CTR_W), .NUM_CTRS(8)) perf_if ();

  vx_perf_cache_reader #(.CTR_W(CTR_W), .NUM_CTRS(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .perf_cache_if (perf_if.slave),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_start     (req_start),
    .req_count     (req_count),
    .req_clear     (req_clear),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_idx       (rsp_idx),
    .rsp_last      (rsp_last)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [CTR_W-1:0] base_m [8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: rsp_ready always high; 1: random ready, live churn, junk requests;
  // 2: ready held low 5 cycles at beat 2 with live churn.
  task automatic readout(input int start, input int cnt, input bit clr, input int mode);
    logic [CTR_W-1:0] snapv [8];
    logic [CTR_W-1:0] exp_d [8];
    int exp_i [8];
    int n, k, cyc, stall;
    bit hs;
    n = (cnt == 0) ? 1 : ((cnt > 8) ? 8 : cnt);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_start = start[2:0];
    req_count = cnt[3:0];
    req_clear = clr;
    for (int i = 0; i < 8; i++) snapv[i] = perf_if.ctr[i];
    for (int b = 0; b < n; b++) begin
      exp_i[b] = (start + b) % 8;
      exp_d[b] = snapv[exp_i[b]] - base_m[exp_i[b]];
    end
    step();
    req_valid = 1'b0;
    req_start = 3'($urandom);
    req_count = 4'($urandom);
    req_clear = 1'($urandom);
    check("snap_cycle_valid", rsp_valid, 0);
    check("snap_cycle_ready", req_ready, 0);
    step();
    check("first_beat_latency", rsp_valid, 1);
    k = 0; cyc = 0; stall = 0;
    while (k < n && cyc < 200) begin
      check("beat_valid", rsp_valid, 1);
      check("beat_idx", rsp_idx, exp_i[k]);
      check("beat_data", rsp_data, exp_d[k]);
      check("beat_last", rsp_last, (k == n - 1));
      check("send_ready", req_ready, 0);
      case (mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = 1'($urandom_range(0, 1));
        default: begin
          if (k == 2 && stall < 5) begin
            rsp_ready = 1'b0;
            stall++;
          end else begin
            rsp_ready = 1'b1;
          end
        end
      endcase
      if (mode != 0) begin
        for (int j = 0; j < 8; j++) perf_if.ctr[j] = perf_if.ctr[j] + CTR_W'($urandom_range(0, 40));
        req_valid = (k < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      hs = rsp_valid && rsp_ready;
      step();
      cyc++;
      if (hs) k++;
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("beats_done", k, n);
    check("idle_after_last_valid", rsp_valid, 0);
    check("idle_after_last_ready", req_ready, 1);
    if (clr) for (int i = 0; i < 8; i++) base_m[i] = snapv[i];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset = 1'b0;
    req_valid = 1'b0; req_start = '0; req_count = '0; req_clear = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      perf_if.ctr[i] = CTR_W'(1000 + i);
      base_m[i] = '0;
    end
    repeat (3) step();
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_last", rsp_last, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_idx", rsp_idx, 0);
    reset = 1'b1;
    step();
    check("ready_after_reset", req_ready, 1);

    // Live 10..17, full in-order readout.
    for (int i = 0; i < 8; i++) perf_if.ctr[i] = CTR_W'(10 + i);
    readout(0, 8, 1'b0, 0);
    // Wrapping window 6,7,0,1.
    readout(6, 4, 1'b0, 0);

    // Clear then delta on reads: 130 - 100 = 30.
    perf_if.ctr[PERF_IDX_READS] = CTR_W'(100);
    readout(0, 8, 1'b1, 0);
    perf_if.ctr[PERF_IDX_READS] = CTR_W'(130);
    readout(PERF_IDX_READS, 1, 1'b0, 0);
    check("reads_delta_30", CTR_W'(perf_if.ctr[PERF_IDX_READS] - base_m[PERF_IDX_READS]), 30);

    // Baseline near 2^CTR_W, counter wrapped to 3 -> delta 8.
    perf_if.ctr[PERF_IDX_READ_MISSES] = {CTR_W{1'b1}} - CTR_W'(4);
    readout(0, 8, 1'b1, 0);
    perf_if.ctr[PERF_IDX_READ_MISSES] = CTR_W'(3);
    readout(PERF_IDX_READ_MISSES, 1, 1'b0, 0);

    // Stall mid-readout while live counters move.
    readout(3, 8, 1'b0, 2);
    // Count saturation at both ends.
    readout(5, 0, 1'b0, 0);
    readout(2, 13, 1'b0, 1);

    // Reset during beat 2 of a clearing readout.
    for (int i = 0; i < 8; i++) perf_if.ctr[i] = perf_if.ctr[i] + CTR_W'(7 * i + 1);
    req_valid = 1'b1; req_start = 3'd0; req_count = 4'd8; req_clear = 1'b1;
    step();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    guard = 0;
    while (!(rsp_valid && rsp_idx == 3'd2) && guard < 10) begin
      step();
      guard++;
    end
    check("reach_beat2", rsp_idx, 2);
    reset = 1'b0;
    rsp_ready = 1'b0;
    step();
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_rsp_last", rsp_last, 0);
    reset = 1'b1;
    step();
    for (int i = 0; i < 8; i++) base_m[i] = '0;
    readout(0, 8, 1'b0, 0);

    // Randomized readouts.
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < 8; i++) perf_if.ctr[i] = CTR_W'({$urandom, $urandom});
      else
        for (int i = 0; i < 8; i++) perf_if.ctr[i] = perf_if.ctr[i] + CTR_W'($urandom_range(0, 5000));
      readout($urandom_range(0, 7), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vx_perf_cache_reader.md
VX_PERF_CACHE_READER -- requirements
Module: VX_perf_cache_reader

Interface
REQ-001 Parameter CTR_W, default `PERF_CTR_BITS, width of every cache perf counter and response word.
REQ-002 Parameter NUM_CTRS, default 8, fixed counter count; index order: reads, writes, read_misses, write_misses, bank_stalls, mshr_stalls, mem_stalls, crsp_stalls (0..7).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 perf_cache_if  slave modport  8xCTR_W  live free-running cache counters (inputs).
REQ-006 req_valid  input  1  readout request valid.
REQ-007 req_ready  output  1  request accepted when req_valid and req_ready are both high.
REQ-008 req_start  input  3  first counter index to return.
REQ-009 req_count  input  4  number of counters to return, legal 1..8.
REQ-010 req_clear  input  1  after readout, rebase all counters to the snapshot.
REQ-011 rsp_valid  output  1  response word valid.
REQ-012 rsp_ready  input  1  consumer accepts word when rsp_valid and rsp_ready are both high.
REQ-013 rsp_data  output  CTR_W  counter value relative to baseline.
REQ-014 rsp_idx  output  3  counter index of rsp_data.
REQ-015 rsp_last  output  1  high on the final word of a readout.

Function
REQ-016 FSM states: IDLE, SNAP, SEND; req_ready high only in IDLE.
REQ-017 Request handshake in IDLE: register req_start, req_count, and req_clear; next cycle enter SNAP.
REQ-018 SNAP (one cycle): capture all 8 live counters at once into snapshot registers; enter SEND; capture is atomic across all 8 counters.
REQ-019 SEND: rsp_valid high; rsp_idx = (start + beat) mod 8, wrapping 7->0; rsp_data = snap[rsp_idx] - base[rsp_idx] modulo 2^CTR_W, so counter wrap-around yields the correct delta.
REQ-020 rsp_data, rsp_idx, and rsp_last held stable while rsp_valid && !rsp_ready.
REQ-021 Each response handshake increments the beat counter; rsp_last = (beat == count-1).
REQ-022 Handshake with rsp_last: if clear latched, base[i] <= snap[i] for all i, same edge; return to IDLE; first new request accepted the following cycle at the earliest.
REQ-023 req_count of 0 treated as 1; req_count above 8 saturated to 8, so at most 8 beats and no index repeated.
REQ-024 Latency: request accept at cycle N -> first rsp_valid at cycle N+2; back-to-back beats when rsp_ready held high.
REQ-025 req_* inputs ignored outside IDLE; live counter changes after SNAP do not alter in-flight data.

Reset
REQ-026 reset low at an edge: FSM <= IDLE, beat <= 0, all base and snap registers <= 0, rsp_valid <= 0, rsp_last <= 0, rsp_data <= 0, rsp_idx <= 0; req_ready high from the first cycle after reset deasserts.
REQ-027 Reset mid-SEND aborts the readout with no further beats; baseline is not updated.

Structure
REQ-028 Counter-index localparams (0..7) and the FSM state enum in a shared VX_perf_pkg, for reuse by the producer side.
REQ-029 One sub-module VX_perf_snap_bank: 8xCTR_W snapshot/baseline register pair with capture, rebase, and indexed delta read; the FSM stays in the top module.

Verification
REQ-030 Live counters 10..17 (idx 0..7); request start=0, count=8, clear=0, rsp_ready=1 -> 8 beats, data 10..17, idx 0..7, rsp_last on beat 7, first beat 2 cycles after accept.
REQ-031 start=6, count=4 -> rsp_idx 6,7,0,1, rsp_last on beat 3.
REQ-032 reads=100; readout with clear=1; reads then 130; request idx0 count=1 -> rsp_data=30.
REQ-033 Baseline 2^CTR_W-5, live counter wrapped to 3 -> rsp_data=8.
REQ-034 rsp_ready low for 5 cycles mid-readout while live counters change -> outputs stable, data equals values captured at SNAP.
REQ-035 reset low during beat 2 of a clear=1 readout -> rsp_valid 0 the next cycle; a fresh readout returns deltas from 0 (baseline cleared by reset).
